// File: rtl/network_config_pkg.sv
// rtl/network_config_pkg.sv - network core geometry shared by the host-side blocks
package network_config;

    localparam int NET_NUM_INP      = 2;
    localparam int NET_CHARGE_WIDTH = 8;

endpackage

// File: rtl/scheduler_config_pkg.sv
// rtl/scheduler_config_pkg.sv - scheduler state encoding and command packet layout
package scheduler_config;

    import network_config::*;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // Packet is {clr, run, charge[0], ..., charge[N-1], count}; offsets depend on the count width.
    localparam int CNT_LSB = 0;

    function automatic int CHG_LSB(input int run_width);
        return CNT_LSB + run_width;
    endfunction

    function automatic int RUN_BIT(input int run_width);
        return CHG_LSB(run_width) + NET_NUM_INP * NET_CHARGE_WIDTH;
    endfunction

    function automatic int CLR_BIT(input int run_width);
        return RUN_BIT(run_width) + 1;
    endfunction

    function automatic int SCH_SRC_WIDTH(input int run_width);
        return 2 + NET_NUM_INP * NET_CHARGE_WIDTH + run_width;
    endfunction

endpackage

// File: rtl/charge_sat_add.sv
// rtl/charge_sat_add.sv - signed saturating adder for one staged input charge
module charge_sat_add #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum
);

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] wide;

    assign wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};

    // Top two bits disagree only when the true sum left the representable range.
    always_comb begin
        sum = wide[WIDTH-1:0];
        if (wide[WIDTH] != wide[WIDTH-1]) begin
            sum = wide[WIDTH] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/network_run_scheduler.sv
// rtl/network_run_scheduler.sv - stages host charges and drives clear/run cycles into the network core
module network_run_scheduler
    import network_config::*;
    import scheduler_config::*;
#(
    parameter int  RUN_WIDTH = 16,
    localparam int SRC_W     = SCH_SRC_WIDTH(RUN_WIDTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               src_valid,
    output logic                               src_ready,
    input  logic [SRC_W-1:0]                   src,
    input  logic                               net_ready,
    output logic                               net_valid,
    output logic                               net_clr,
    output logic signed [NET_CHARGE_WIDTH-1:0] net_inp [0:NET_NUM_INP-1],
    output logic                               out_ready,
    output logic                               busy
);

    localparam int NI    = NET_NUM_INP;
    localparam int CW    = NET_CHARGE_WIDTH;
    localparam int CLR_B = CLR_BIT(RUN_WIDTH);
    localparam int RUN_B = RUN_BIT(RUN_WIDTH);
    localparam int CHG_L = CHG_LSB(RUN_WIDTH);
    localparam logic [RUN_WIDTH-1:0] ONE = {{(RUN_WIDTH-1){1'b0}}, 1'b1};

    sched_state_t          state;
    logic [RUN_WIDTH-1:0]  remaining;
    logic                  first;
    logic                  run_q;
    logic signed [CW-1:0]  staged [0:NI-1];
    logic signed [CW-1:0]  charge [0:NI-1];
    logic signed [CW-1:0]  acc    [0:NI-1];

    logic                  pkt_clr;
    logic                  pkt_run;
    logic [RUN_WIDTH-1:0]  pkt_count;
    logic                  accept;

    assign pkt_clr   = src[CLR_B];
    assign pkt_run   = src[RUN_B];
    assign pkt_count = src[CNT_LSB +: RUN_WIDTH];
    assign accept    = src_valid & src_ready;

    // Input 0 sits in the most significant charge slot.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            charge[i] = src[CHG_L + (NI-1-i)*CW +: CW];
        end
    end

    for (genvar g = 0; g < NI; g++) begin : g_acc
        charge_sat_add #(.WIDTH(CW)) u_sat_add (
            .a   (staged[g]),
            .b   (charge[g]),
            .sum (acc[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            first     <= 1'b0;
            run_q     <= 1'b0;
            for (int i = 0; i < NI; i++) staged[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        remaining <= pkt_count;
                        first     <= 1'b1;
                        run_q     <= pkt_run;
                        for (int i = 0; i < NI; i++) begin
                            staged[i] <= pkt_clr ? charge[i] : acc[i];
                        end
                        if (pkt_clr) begin
                            state <= ST_CLEAR;
                        end else if (pkt_run && (pkt_count != '0)) begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (net_ready) begin
                        state <= (run_q && (remaining != '0)) ? ST_RUN : ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (net_ready) begin
                        remaining <= remaining - ONE;
                        // Charges are injected once; later cycles let the network evolve on its own.
                        if (first) begin
                            first <= 1'b0;
                            for (int i = 0; i < NI; i++) staged[i] <= '0;
                        end
                        if (remaining == ONE) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign src_ready = ~rst & (state == ST_IDLE);
    assign net_valid = ~rst & (state == ST_RUN);
    assign net_clr   = ~rst & (state == ST_CLEAR);
    assign out_ready = ~rst & (state == ST_DONE);
    assign busy      = ~rst & (state != ST_IDLE);

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            net_inp[i] = (net_valid && first) ? staged[i] : '0;
        end
    end

endmodule

// File: tb/tb_network_run_scheduler.sv
// tb/tb_network_run_scheduler.sv - randomized self-checking bench for network_run_scheduler
module tb_network_run_scheduler;

    import network_config::*;
    import scheduler_config::*;

    localparam int RW = 8;
    localparam int SW = SCH_SRC_WIDTH(RW);

    logic                               clk = 1'b0;
    logic                               rst;
    logic                               src_valid;
    logic                               src_ready;
    logic [SW-1:0]                      src;
    logic                               net_ready;
    logic                               net_valid;
    logic                               net_clr;
    logic signed [NET_CHARGE_WIDTH-1:0] net_inp [0:NET_NUM_INP-1];
    logic                               out_ready;
    logic                               busy;

    network_run_scheduler #(.RUN_WIDTH(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src       (src),
        .net_ready (net_ready),
        .net_valid (net_valid),
        .net_clr   (net_clr),
        .net_inp   (net_inp),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: staged charges as plain integers, expected handshake data as queues.
    int model_st [2];
    int e0 [$];
    int e1 [$];

    int hs0 [$];
    int hs1 [$];
    int obs_out, obs_clr_cyc, obs_overlap, obs_stall_bad;
    int obs_first_valid, obs_last_hs, obs_out_cyc, obs_src_cyc;
    bit obs_timeout;

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_cmd(input bit clr, input bit run, input int count, input int c0, input int c1);
        if (clr) begin
            model_st[0] = c0;
            model_st[1] = c1;
        end else begin
            model_st[0] = sat8(model_st[0] + c0);
            model_st[1] = sat8(model_st[1] + c1);
        end
        e0.delete();
        e1.delete();
        if (run && count != 0) begin
            for (int k = 0; k < count; k++) begin
                e0.push_back(k == 0 ? model_st[0] : 0);
                e1.push_back(k == 0 ? model_st[1] : 0);
            end
            model_st[0] = 0;
            model_st[1] = 0;
        end
    endtask

    // mode 0: net_ready always high; 1: pattern 1,0,0,1,1 over net_valid cycles; 2: random.
    task automatic do_cmd(input bit clr, input bit run, input int count, input int c0, input int c1,
                          input int mode);
        logic [7:0]    b0, b1;
        logic [RW-1:0] cn;
        bit            pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bit            stalled;
        int            pv0, pv1, vidx, w;
        hs0.delete(); hs1.delete();
        obs_out = 0; obs_clr_cyc = 0; obs_overlap = 0; obs_stall_bad = 0;
        obs_first_valid = -1; obs_last_hs = -1; obs_out_cyc = -1; obs_src_cyc = -1;
        obs_timeout = 1'b0;
        stalled = 1'b0; pv0 = 0; pv1 = 0; vidx = 0; w = 0;
        b0 = c0[7:0]; b1 = c1[7:0]; cn = count[RW-1:0];
        @(negedge clk);
        while (!src_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) obs_timeout = 1'b1;
        src = {clr, run, b0, b1, cn};
        src_valid = 1'b1;
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        model_cmd(clr, run, count, c0, c1);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (mode == 0) net_ready = 1'b1;
            else if (mode == 1) net_ready = (net_valid && vidx < 5) ? pat[vidx] : 1'b1;
            else net_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (net_valid && net_clr) obs_overlap++;
            if (net_clr) obs_clr_cyc++;
            if (net_valid) begin
                if (stalled && (int'(net_inp[0]) != pv0 || int'(net_inp[1]) != pv1)) obs_stall_bad++;
                if (obs_first_valid < 0) obs_first_valid = cyc;
                if (net_ready) begin
                    hs0.push_back(int'(net_inp[0]));
                    hs1.push_back(int'(net_inp[1]));
                    obs_last_hs = cyc;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pv0 = int'(net_inp[0]);
                    pv1 = int'(net_inp[1]);
                end
                vidx++;
            end
            if (out_ready) begin
                obs_out++;
                obs_out_cyc = cyc;
            end
            if (src_ready) begin
                obs_src_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (obs_src_cyc < 0) obs_timeout = 1'b1;
        net_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src_valid = 1'b1;
        src = {1'b0, 1'b1, 8'd5, 8'd5, 8'd2};
        net_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({src_ready, net_valid, net_clr, out_ready, busy} !== 5'b0 ||
                net_inp[0] !== 8'sd0 || net_inp[1] !== 8'sd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d got ready/valid/clr/out/busy=%b inp=(%0d,%0d) want all 0",
                         k, {src_ready, net_valid, net_clr, out_ready, busy}, net_inp[0], net_inp[1]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        src_valid = 1'b0;
        net_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (src_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got src_ready=%b busy=%b want 1 0", src_ready, busy);
        end
        model_st[0] = 0;
        model_st[1] = 0;
    endtask

    task automatic test_run();
        do_cmd(1'b0, 1'b1, 3, 5, -2, 0);
        checks++;
        if (hs0.size() != 3 || hs0[0] != 5 || hs1[0] != -2 || hs0[1] != 0 || hs1[1] != 0 ||
            hs0[2] != 0 || hs1[2] != 0) begin
            errors++;
            $display("FAIL run_data got %0d handshakes first=(%0d,%0d) want 3 x (5,-2),(0,0),(0,0)",
                     hs0.size(), hs0.size() > 0 ? hs0[0] : 999, hs1.size() > 0 ? hs1[0] : 999);
        end
        checks++;
        if (obs_out != 1 || obs_first_valid != 1 || obs_out_cyc != obs_last_hs + 1 ||
            obs_src_cyc != obs_out_cyc + 1 || obs_timeout) begin
            errors++;
            $display("FAIL run_timing got out=%0d first_valid=%0d last_hs=%0d out_cyc=%0d src_cyc=%0d want 1 1 3 4 5",
                     obs_out, obs_first_valid, obs_last_hs, obs_out_cyc, obs_src_cyc);
        end
    endtask

    task automatic test_saturate();
        do_cmd(1'b0, 1'b0, 0, 100, -100, 0);
        do_cmd(1'b0, 1'b1, 1, 100, -100, 0);
        checks++;
        if (hs0.size() != 1 || hs0[0] != 127 || hs1[0] != -128) begin
            errors++;
            $display("FAIL saturate got n=%0d (%0d,%0d) want 1 (127,-128)",
                     hs0.size(), hs0.size() > 0 ? hs0[0] : 999, hs1.size() > 0 ? hs1[0] : 999);
        end
    endtask

    task automatic test_clear();
        do_cmd(1'b0, 1'b0, 0, 7, 7, 0);
        do_cmd(1'b1, 1'b1, 2, 1, 0, 0);
        checks++;
        if (obs_clr_cyc != 1 || obs_first_valid != 2 || obs_overlap != 0) begin
            errors++;
            $display("FAIL clear_timing got clr_cycles=%0d first_valid=%0d overlap=%0d want 1 2 0",
                     obs_clr_cyc, obs_first_valid, obs_overlap);
        end
        checks++;
        if (hs0.size() != 2 || hs0[0] != 1 || hs1[0] != 0 || hs0[1] != 0 || hs1[1] != 0 || obs_out != 1) begin
            errors++;
            $display("FAIL clear_data got n=%0d first=(%0d,%0d) out=%0d want 2 (1,0),(0,0) out 1",
                     hs0.size(), hs0.size() > 0 ? hs0[0] : 999, hs1.size() > 0 ? hs1[0] : 999, obs_out);
        end
    endtask

    task automatic test_backpressure();
        do_cmd(1'b0, 1'b1, 3, 5, -2, 1);
        checks++;
        if (hs0.size() != 3 || hs0[0] != 5 || hs1[0] != -2 || obs_stall_bad != 0) begin
            errors++;
            $display("FAIL backpressure_data got n=%0d first=(%0d,%0d) stall_changes=%0d want 3 (5,-2) 0",
                     hs0.size(), hs0.size() > 0 ? hs0[0] : 999, hs1.size() > 0 ? hs1[0] : 999, obs_stall_bad);
        end
        checks++;
        if (obs_last_hs != 5 || obs_out != 1 || obs_out_cyc != 6) begin
            errors++;
            $display("FAIL backpressure_timing got last_hs=%0d out=%0d out_cyc=%0d want 5 1 6",
                     obs_last_hs, obs_out, obs_out_cyc);
        end
    endtask

    task automatic test_zero_count();
        do_cmd(1'b0, 1'b1, 0, 3, 3, 0);
        checks++;
        if (hs0.size() != 0 || obs_first_valid != -1 || obs_out != 0 || obs_src_cyc != 1) begin
            errors++;
            $display("FAIL zero_count got handshakes=%0d valid_at=%0d out=%0d src_cyc=%0d want 0 -1 0 1",
                     hs0.size(), obs_first_valid, obs_out, obs_src_cyc);
        end
        do_cmd(1'b0, 1'b1, 1, 0, 0, 0);
        checks++;
        if (hs0.size() != 1 || hs0[0] != 3 || hs1[0] != 3) begin
            errors++;
            $display("FAIL zero_count_kept got n=%0d (%0d,%0d) want 1 (3,3)",
                     hs0.size(), hs0.size() > 0 ? hs0[0] : 999, hs1.size() > 0 ? hs1[0] : 999);
        end
    endtask

    task automatic test_mid_reset();
        int seen_out;
        seen_out = 0;
        @(negedge clk);
        src = {1'b0, 1'b1, 8'd4, 8'd4, 8'd5};
        src_valid = 1'b1;
        net_ready = 1'b1;
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({src_ready, net_valid, net_clr, out_ready, busy} !== 5'b0) begin
            errors++;
            $display("FAIL midreset_outputs got %b want 00000", {src_ready, net_valid, net_clr, out_ready, busy});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_ready || net_valid) seen_out++;
        end
        checks++;
        if (seen_out != 0 || src_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle got activity=%0d src_ready=%b busy=%b want 0 1 0", seen_out, src_ready, busy);
        end
        net_ready = 1'b0;
        do_cmd(1'b0, 1'b0, 0, 9, 9, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_st[0] = 0;
        model_st[1] = 0;
        do_cmd(1'b0, 1'b1, 1, 0, 0, 0);
        checks++;
        if (hs0.size() != 1 || hs0[0] != 0 || hs1[0] != 0) begin
            errors++;
            $display("FAIL midreset_staged got n=%0d (%0d,%0d) want 1 (0,0)",
                     hs0.size(), hs0.size() > 0 ? hs0[0] : 999, hs1.size() > 0 ? hs1[0] : 999);
        end
    endtask

    task automatic test_random();
        bit clr, run;
        int count, c0, c1, mode, bad;
        for (int it = 0; it < 25; it++) begin
            clr   = ($urandom_range(0, 3) == 0);
            run   = ($urandom_range(0, 2) != 0);
            count = $urandom_range(0, 4);
            c0    = int'($urandom_range(0, 255)) - 128;
            c1    = int'($urandom_range(0, 255)) - 128;
            mode  = ($urandom_range(0, 1) == 0) ? 0 : 2;
            do_cmd(clr, run, count, c0, c1, mode);
            bad = 0;
            if (hs0.size() != e0.size()) bad = 1;
            else for (int k = 0; k < e0.size(); k++) if (hs0[k] != e0[k] || hs1[k] != e1[k]) bad = 1;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL random_data iter %0d got n=%0d first=(%0d,%0d) want n=%0d first=(%0d,%0d)",
                         it, hs0.size(), hs0.size() > 0 ? hs0[0] : 999, hs1.size() > 0 ? hs1[0] : 999,
                         e0.size(), e0.size() > 0 ? e0[0] : 999, e1.size() > 0 ? e1[0] : 999);
            end
            checks++;
            if (obs_out != ((run && count != 0) ? 1 : 0) || obs_overlap != 0 || obs_timeout ||
                (obs_clr_cyc != 0) != clr || obs_stall_bad != 0) begin
                errors++;
                $display("FAIL random_ctrl iter %0d got out=%0d overlap=%0d timeout=%0d clr_cycles=%0d stall=%0d",
                         it, obs_out, obs_overlap, obs_timeout, obs_clr_cyc, obs_stall_bad);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        src_valid = 1'b0;
        src = '0;
        net_ready = 1'b0;
        test_reset();
        test_run();
        test_saturate();
        test_clear();
        test_backpressure();
        test_zero_count();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
